fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W   = 32;
    localparam int          PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of a 1-cycle-latency synchronous imem.
// Owns the fetch PC, tags returning words with their PC, squashes wrong-path
// words after a redirect and holds the presented word while IF/ID stalls.
// Optional build macro FETCH_PERF_EN adds accepted-instruction and bubble
// counters (perf_fetched, perf_bubbles).
//
// state | meaning
// IDLE  | first cycle after reset, nothing in flight yet
// RUN   | imem_dout carries the word fetched last cycle (tagged by req_pc)
// HOLD  | IF/ID stalled, presenting the captured word from hold regs
// FLUSH | redirect pending, whatever imem returns is wrong-path and dropped
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jmp,
    input  logic [31:0]        jmp_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_dout,
    output logic [31:0]        pc_out,
    output logic [INSTR_W-1:0] instruction,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles,
`endif
    output logic               valid
);

    fetch_state_t       state, state_n;
    logic [31:0]        fpc;
    logic [31:0]        req_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [31:0]        hold_pc;

    logic               issue;
    logic               redirect;
    logic               capture;
    logic               valid_c;
    logic [31:0]        pc_c;
    logic [INSTR_W-1:0] instr_c;

    // Next-state, issue/redirect decisions and presented outputs.
    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        redirect = 1'b0;
        capture  = 1'b0;
        valid_c  = 1'b0;
        pc_c     = 32'h0;
        instr_c  = NOP_INSTR;
        case (state)
            IDLE: begin
                if (jmp) begin
                    redirect = 1'b1;
                    state_n  = FLUSH;
                end else begin
                    issue   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                pc_c    = req_pc;
                instr_c = imem_dout;
                if (jmp) begin
                    redirect = 1'b1;
                    state_n  = FLUSH;
                end else begin
                    valid_c = 1'b1;
                    if (stall) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            HOLD: begin
                pc_c    = hold_pc;
                instr_c = hold_instr;
                if (jmp) begin
                    redirect = 1'b1;
                    state_n  = FLUSH;
                end else begin
                    valid_c = 1'b1;
                    if (!stall) begin
                        // Held word is consumed now; next word lands next cycle.
                        issue   = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            FLUSH: begin
                // Stall is ignored here: nothing valid is presented to hold.
                if (jmp) begin
                    redirect = 1'b1;
                end else begin
                    issue   = 1'b1;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (reset) begin
            issue    = 1'b0;
            redirect = 1'b0;
            capture  = 1'b0;
            valid_c  = 1'b0;
            pc_c     = 32'h0;
            instr_c  = '0;
        end
    end

    assign imem_en     = issue;
    assign imem_addr   = fpc[ADDR_W+1:2];
    assign valid       = valid_c;
    assign pc_out      = pc_c;
    assign instruction = instr_c;

    // State register, fetch PC, in-flight tag and stall capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            req_pc     <= 32'h0;
            hold_instr <= '0;
            hold_pc    <= 32'h0;
        end else begin
            state <= state_n;
            if (redirect) begin
                fpc <= align_pc(jmp_pc);
            end else if (issue) begin
                req_pc <= fpc;
                fpc    <= fpc + 32'(PC_INC);
            end
            if (capture) begin
                hold_instr <= imem_dout;
                hold_pc    <= req_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Accepted-instruction and bubble counters, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
        end else begin
            if (valid_c && !stall) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!valid_c) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, a redirect-storm
// sequence, then randomized traffic against a PC-stream reference model.
module tb_fetch_ctrl;

    localparam int          ADDR_W   = 9;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_RAND   = 4000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              jmp = 1'b0;
    logic [31:0]       jmp_pc = 32'h0;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_dout = 32'h0;
    logic [31:0]       pc_out;
    logic [31:0]       instruction;
    logic              valid;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_bubbles;
`endif

    fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jmp         (jmp),
        .jmp_pc      (jmp_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .pc_out      (pc_out),
        .instruction (instruction),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles),
`endif
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds value k, 1-cycle read latency.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'(k);
    end
    always @(posedge clk) begin
        if (imem_en) imem_dout <= mem[imem_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] widx(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return w[ADDR_W-1:0];
    endfunction

    typedef struct {
        logic              rst;
        logic              stl;
        logic              jp;
        logic [31:0]       jpc;
        logic              ev;
        logic [31:0]       epc;
        logic [31:0]       ei;
        logic              een;
        logic [ADDR_W-1:0] ea;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic stl, input logic jp, input logic [31:0] jpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                       input logic een, input logic [ADDR_W-1:0] ea);
        vec_t v;
        v.rst = rst; v.stl = stl; v.jp = jp; v.jpc = jpc;
        v.ev = ev; v.epc = epc; v.ei = ei; v.een = een; v.ea = ea;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] jp);
        @(negedge clk);
        reset = r; stall = s; jmp = j; jmp_pc = jp;
        #1;
    endtask

    // Reference model: stream of presented PCs
    bit          m_gap;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_fetched;
    logic [31:0] m_bubbles;

    initial begin
        // ---------------- directed vector table ----------------
        add(1,0,0,32'h0,          0,32'h0,0,           0,0);   // reset
        add(0,0,0,32'h0,          0,32'h0,0,           1,0);   // IDLE issues RESET_PC
        add(0,0,0,32'h0,          1,32'h0,0,           1,1);
        add(0,0,0,32'h0,          1,32'h4,1,           1,2);
        add(0,1,0,32'h0,          1,32'h8,2,           0,0);   // stall x3 on pc 8
        add(0,1,0,32'h0,          1,32'h8,2,           0,0);
        add(0,1,0,32'h0,          1,32'h8,2,           0,0);
        add(0,0,0,32'h0,          1,32'h8,2,           1,3);   // release
        add(0,0,0,32'h0,          1,32'hC,3,           1,4);
        add(0,0,1,32'h40,         0,32'h0,0,           0,0);   // jmp while pc 0x10
        add(0,0,0,32'h0,          0,32'h0,0,           1,16);  // FLUSH issues 0x40
        add(0,0,0,32'h0,          1,32'h40,16,         1,17);
        add(0,1,0,32'h0,          1,32'h44,17,         0,0);   // into HOLD
        add(0,1,1,32'h80,         0,32'h0,0,           0,0);   // jmp beats stall
        add(0,0,1,32'hC0,         0,32'h0,0,           0,0);   // back-to-back jmp
        add(0,1,0,32'h0,          0,32'h0,0,           1,48);  // FLUSH ignores stall
        add(0,0,0,32'h0,          1,32'hC0,48,         1,49);
        add(0,0,1,32'h803,        0,32'h0,0,           0,0);   // misaligned target
        add(0,0,0,32'h0,          0,32'h0,0,           1,0);   // 0x800 wraps to addr 0
        add(0,0,0,32'h0,          1,32'h800,0,         1,1);
        add(0,1,0,32'h0,          1,32'h804,1,         0,0);   // into HOLD
        add(1,1,0,32'h0,          0,32'h0,0,           0,0);   // reset mid-HOLD
        add(0,0,0,32'h0,          0,32'h0,0,           1,0);
        add(0,0,1,32'hFFFF_FFFC,  0,32'h0,0,           0,0);
        add(0,0,0,32'h0,          0,32'h0,0,           1,511);
        add(0,0,0,32'h0,          1,32'hFFFF_FFFC,511, 1,0);   // fpc wraps to 0
        add(0,0,0,32'h0,          1,32'h0,0,           1,1);
        add(0,0,1,32'h100,        0,32'h0,0,           0,0);
        add(1,0,0,32'h0,          0,32'h0,0,           0,0);   // reset mid-FLUSH
        add(0,0,0,32'h0,          0,32'h0,0,           1,0);
        add(0,0,0,32'h0,          1,32'h0,0,           1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].jp, tbl[i].jpc);
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].rst) begin
                chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].epc);
                chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].ei);
            end
            chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(tbl[i].een));
            if (tbl[i].een) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].ea));
`ifdef FETCH_PERF_EN
            if (i == 29) begin
                chk("tbl_perf_fetched_after_reset", perf_fetched, 32'h0);
                chk("tbl_perf_bubbles_after_reset", perf_bubbles, 32'h0);
            end
`endif
        end

        // ---------------- redirect storm: only last target presented ----------------
        drive(1, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(0, k[0], 1, 32'h200 + 32'(16 * k) + 32'(k));
            chk($sformatf("storm%0d_valid", k), 32'(valid), 32'h0);
            chk($sformatf("storm%0d_en", k), 32'(imem_en), 32'h0);
        end
        drive(0, 1, 0, 32'h0);
        chk("storm_flush_valid", 32'(valid), 32'h0);
        chk("storm_flush_addr", 32'(imem_addr), 32'(widx(32'h230)));
        drive(0, 0, 0, 32'h0);
        chk("storm_tgt_valid", 32'(valid), 32'h1);
        chk("storm_tgt_pc", pc_out, 32'h230);
        chk("storm_tgt_instr", instruction, 32'(widx(32'h230)));
        drive(0, 0, 0, 32'h0);
        chk("storm_next_pc", pc_out, 32'h234);

        // ---------------- randomized traffic vs model ----------------
        for (int c = 0; c < N_RAND; c++) begin
            logic        r, s, j;
            logic [31:0] jp;
            r  = (c == 0) || ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 9) == 0);
            jp = $urandom;
            drive(r, s, j, jp);
`ifdef FETCH_PERF_EN
            if (!r && c > 0) begin
                chk("rnd_perf_fetched", perf_fetched, m_fetched);
                chk("rnd_perf_bubbles", perf_bubbles, m_bubbles);
            end
`endif
            if (r) begin
                chk("rnd_rst_valid", 32'(valid), 32'h0);
                chk("rnd_rst_pc", pc_out, 32'h0);
                chk("rnd_rst_instr", instruction, 32'h0);
                chk("rnd_rst_en", 32'(imem_en), 32'h0);
                m_gap = 1'b1;
                m_tgt = RESET_PC;
                m_fetched = 32'h0;
                m_bubbles = 32'h0;
            end else if (m_gap) begin
                chk("rnd_gap_valid", 32'(valid), 32'h0);
                m_bubbles = m_bubbles + 32'd1;
                if (j) begin
                    chk("rnd_gap_jmp_en", 32'(imem_en), 32'h0);
                    m_tgt = {jp[31:2], 2'b00};
                end else begin
                    chk("rnd_gap_en", 32'(imem_en), 32'h1);
                    chk("rnd_gap_addr", 32'(imem_addr), 32'(widx(m_tgt)));
                    m_pc  = m_tgt;
                    m_gap = 1'b0;
                end
            end else if (j) begin
                chk("rnd_jmp_valid", 32'(valid), 32'h0);
                chk("rnd_jmp_en", 32'(imem_en), 32'h0);
                m_bubbles = m_bubbles + 32'd1;
                m_tgt = {jp[31:2], 2'b00};
                m_gap = 1'b1;
            end else begin
                chk("rnd_valid", 32'(valid), 32'h1);
                chk("rnd_pc", pc_out, m_pc);
                chk("rnd_instr", instruction, mem[widx(m_pc)]);
                if (s) begin
                    chk("rnd_stall_en", 32'(imem_en), 32'h0);
                end else begin
                    chk("rnd_en", 32'(imem_en), 32'h1);
                    chk("rnd_addr", 32'(imem_addr), 32'(widx(m_pc + 32'd4)));
                    m_pc = m_pc + 32'd4;
                    m_fetched = m_fetched + 32'd1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
